// File: rtl/present_decrypt.sv
// Iterative PRESENT-128 decryptor: forward key expansion, then one inverse round per clock.
// Latency: 2*NR cycles from load to done, or NR cycles when the cached last-round key is reused.
// Backpressure: none; load is always accepted and abandons any block in flight.
module present_decrypt #(
  parameter int NR = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         key_reuse,
  input  logic [63:0]  in_data,
  input  logic [127:0] key,
  output logic [63:0]  out_data,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  localparam logic [4:0] NR_C = 5'(NR);

  state_t         state, state_nxt;
  logic [4:0]     cnt, cnt_nxt;
  logic [127:0]   key_reg, key_nxt;
  logic [63:0]    data, data_nxt;
  logic [127:0]   cache, cache_nxt;
  logic           cache_valid, cache_valid_nxt;
  logic [63:0]    out_nxt;
  logic           done_nxt, busy_nxt;
  logic [127:0]   k_fwd, k_bwd;
  logic [63:0]    dec_val;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward schedule step: rotate left 61, S-box top byte, fold in round counter.
  function automatic logic [127:0] key_upd(input logic [127:0] k, input logic [4:0] i);
    logic [127:0] r;
    r          = {k[66:0], k[127:67]};
    r[127:124] = sbox(r[127:124]);
    r[123:120] = sbox(r[123:120]);
    r[66:62]   = r[66:62] ^ i;
    return r;
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [4:0] i);
    logic [127:0] t;
    t          = k;
    t[66:62]   = t[66:62] ^ i;
    t[127:124] = sbox_inv(t[127:124]);
    t[123:120] = sbox_inv(t[123:120]);
    return {t[60:0], t[127:61]};
  endfunction

  function automatic logic [63:0] inv_perm(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        r[4*i+k] = d[16*k+i];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] inv_sub(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = sbox_inv(d[4*n +: 4]);
    end
    return r;
  endfunction

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    key_nxt         = key_reg;
    data_nxt        = data;
    cache_nxt       = cache;
    cache_valid_nxt = cache_valid;
    out_nxt         = out_data;
    done_nxt        = done;
    busy_nxt        = busy;

    k_fwd   = key_upd(key_reg, cnt);
    k_bwd   = key_inv(key_reg, cnt);
    dec_val = inv_sub(inv_perm(data)) ^ k_bwd[127:64];

    if (load) begin
      data_nxt = in_data;
      done_nxt = 1'b0;
      busy_nxt = 1'b1;
      if (key_reuse && cache_valid) begin
        // Cached key is already the last round key: whiten and go straight to rounds.
        key_nxt   = cache;
        data_nxt  = in_data ^ cache[127:64];
        cnt_nxt   = NR_C;
        state_nxt = DEC;
      end else begin
        key_nxt   = key;
        cnt_nxt   = 5'd1;
        state_nxt = KEXP;
      end
    end else begin
      case (state)
        KEXP: begin
          key_nxt = k_fwd;
          cnt_nxt = cnt + 5'd1;
          if (cnt == NR_C) begin
            data_nxt        = data ^ k_fwd[127:64];
            cache_nxt       = k_fwd;
            cache_valid_nxt = 1'b1;
            cnt_nxt         = NR_C;
            state_nxt       = DEC;
          end
        end
        DEC: begin
          key_nxt  = k_bwd;
          data_nxt = dec_val;
          cnt_nxt  = cnt - 5'd1;
          if (cnt == 5'd1) begin
            out_nxt   = dec_val;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      key_reg     <= '0;
      data        <= '0;
      cache       <= '0;
      cache_valid <= 1'b0;
      out_data    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_reg     <= key_nxt;
      data        <= data_nxt;
      cache       <= cache_nxt;
      cache_valid <= cache_valid_nxt;
      out_data    <= out_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_present_decrypt.sv
// Bench for present_decrypt: ciphertexts come from a forward PRESENT-128 model,
// and the decryptor must return the original plaintext with the right latency.
module tb_present_decrypt;

  localparam int NR = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load4, load31, key_reuse;
  logic [63:0]  in_data;
  logic [127:0] key;
  logic [63:0]  out4, out31;
  logic         done4, done31, busy4, busy31;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_decrypt #(.NR(NR)) u4 (
    .clk(clk), .rst(rst), .load(load4), .key_reuse(key_reuse),
    .in_data(in_data), .key(key), .out_data(out4), .done(done4), .busy(busy4)
  );

  present_decrypt #(.NR(31)) u31 (
    .clk(clk), .rst(rst), .load(load31), .key_reuse(key_reuse),
    .in_data(in_data), .key(key), .out_data(out31), .done(done31), .busy(busy31)
  );

  // Forward cipher: addRoundKey, S-layer, P-layer per round, then final whitening.
  function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [127:0] k, input int nr);
    logic [127:0] kk;
    logic [63:0]  s, t;
    logic [4:0]   rc;
    kk = k;
    s  = p;
    for (int r = 1; r <= nr; r++) begin
      s = s ^ kk[127:64];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int j = 0; j < 64; j++) t[(j % 4) * 16 + j / 4] = s[j];
      s  = t;
      rc = 5'(r);
      kk = {kk[66:0], kk[127:67]};
      kk[127:124] = SB[kk[127:124]];
      kk[123:120] = SB[kk[123:120]];
      kk[66:62]   = kk[66:62] ^ rc;
    end
    return s ^ kk[127:64];
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start(input logic [63:0] c, input logic [127:0] k, input logic reuse);
    @(negedge clk);
    in_data   = c;
    key       = k;
    key_reuse = reuse;
    load4     = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
  endtask

  // Called just after the load edge; counts cycles and busy samples until done.
  task automatic wait_done(input int which, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (((which == 31) ? done31 : done4) !== 1'b1 && lat < 200) begin
      if (((which == 31) ? busy31 : busy4) === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load4 = 1'b0; load31 = 1'b0; key_reuse = 1'b0;
    in_data = '0; key = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out4, done4, busy4} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_nr4: out=%h done=%b busy=%b, want all zero", out4, done4, busy4);
    end
    vectors++;
    if ({out31, done31, busy31} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_nr31: out=%h done=%b busy=%b, want all zero", out31, done31, busy31);
    end
    rst = 1'b0;
  endtask

  task automatic test_nr31_vector();
    int lat, bn;
    @(negedge clk);
    in_data = 64'h96db702a2e6900af; key = '0; key_reuse = 1'b0; load31 = 1'b1;
    @(negedge clk);
    load31 = 1'b0;
    wait_done(31, lat, bn);
    vectors++;
    if (lat != 62) begin
      miscompares++;
      $display("FAIL nr31_latency: got %0d cycles, want 62", lat);
    end
    vectors++;
    if (out31 !== 64'h0) begin
      miscompares++;
      $display("FAIL nr31_plaintext: got %h, want 0000000000000000", out31);
    end
  endtask

  task automatic test_roundtrip(input logic [63:0] p, input logic [127:0] k);
    int lat, bn;
    start(encrypt(p, k, NR), k, 1'b0);
    wait_done(4, lat, bn);
    vectors++;
    if (lat != 2*NR || bn != 2*NR) begin
      miscompares++;
      $display("FAIL roundtrip_timing: latency %0d busy %0d, want %0d and %0d", lat, bn, 2*NR, 2*NR);
    end
    vectors++;
    if (out4 !== p || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL roundtrip_data: out=%h busy=%b, want %h busy=0", out4, busy4, p);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done4 !== 1'b1 || out4 !== p) begin
      miscompares++;
      $display("FAIL idle_hold: done=%b out=%h, want 1 and %h", done4, out4, p);
    end
  endtask

  // Second block under the cached key; the key port carries junk that must be ignored.
  task automatic test_reuse(input logic [127:0] k);
    int lat, bn;
    logic [63:0] p;
    p = {$urandom, $urandom};
    start(encrypt(p, k, NR), rand_key(), 1'b1);
    wait_done(4, lat, bn);
    vectors++;
    if (lat != NR || out4 !== p) begin
      miscompares++;
      $display("FAIL reuse: latency %0d out=%h, want %0d and %h", lat, out4, NR, p);
    end
  endtask

  task automatic test_reuse_after_rst(input logic [127:0] k);
    int lat, bn;
    logic [63:0] p;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    p = {$urandom, $urandom};
    start(encrypt(p, k, NR), k, 1'b1);
    wait_done(4, lat, bn);
    vectors++;
    if (lat != 2*NR || out4 !== p) begin
      miscompares++;
      $display("FAIL reuse_after_rst: latency %0d out=%h, want %0d and %h", lat, out4, 2*NR, p);
    end
  endtask

  // Abort mid-KEXP with a reuse load: the aborted expansion must not disturb the cache.
  task automatic test_abort_kexp(input logic [127:0] k_cached);
    int lat, bn;
    logic [63:0] p;
    logic [127:0] k2;
    k2 = rand_key();
    start({$urandom, $urandom}, k2, 1'b0);
    p = {$urandom, $urandom};
    start(encrypt(p, k_cached, NR), k2, 1'b1);
    vectors++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_kexp_flags: done=%b busy=%b, want 0 and 1", done4, busy4);
    end
    wait_done(4, lat, bn);
    vectors++;
    if (lat != NR || out4 !== p) begin
      miscompares++;
      $display("FAIL abort_kexp_result: latency %0d out=%h, want %0d and %h", lat, out4, NR, p);
    end
  endtask

  task automatic test_abort_dec(output logic [127:0] k_new);
    int lat, bn;
    logic [63:0] prev, p;
    prev = out4;
    start({$urandom, $urandom}, rand_key(), 1'b0);
    repeat (5) @(negedge clk);
    k_new = rand_key();
    p = {$urandom, $urandom};
    start(encrypt(p, k_new, NR), k_new, 1'b0);
    vectors++;
    if (done4 !== 1'b0 || out4 !== prev) begin
      miscompares++;
      $display("FAIL abort_dec_flags: done=%b out=%h, want 0 and %h", done4, out4, prev);
    end
    wait_done(4, lat, bn);
    vectors++;
    if (lat != 2*NR || out4 !== p) begin
      miscompares++;
      $display("FAIL abort_dec_result: latency %0d out=%h, want %0d and %h", lat, out4, 2*NR, p);
    end
  endtask

  task automatic test_rst_mid_dec(input logic [127:0] k);
    int lat, bn;
    logic [63:0] p;
    start({$urandom, $urandom}, k, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1; load4 = 1'b1; key_reuse = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out4, done4, busy4} !== 66'd0) begin
      miscompares++;
      $display("FAIL rst_mid_dec: out=%h done=%b busy=%b, want all zero", out4, done4, busy4);
    end
    rst = 1'b0; load4 = 1'b0;
    p = {$urandom, $urandom};
    start(encrypt(p, k, NR), k, 1'b1);
    wait_done(4, lat, bn);
    vectors++;
    if (lat != 2*NR || out4 !== p) begin
      miscompares++;
      $display("FAIL rst_then_reuse: latency %0d out=%h, want %0d and %h", lat, out4, 2*NR, p);
    end
  endtask

  task automatic test_random();
    int lat, bn, want_lat;
    logic [63:0] p;
    logic [127:0] k, kport;
    k = '0;
    for (int i = 0; i < 200; i++) begin
      p = {$urandom, $urandom};
      if (i % 2 == 0) begin
        k        = rand_key();
        kport    = k;
        want_lat = 2*NR;
      end else begin
        kport    = rand_key();
        want_lat = NR;
      end
      start(encrypt(p, k, NR), kport, 1'(i % 2));
      wait_done(4, lat, bn);
      vectors++;
      if (lat != want_lat || bn != want_lat || out4 !== p) begin
        miscompares++;
        $display("FAIL random[%0d]: latency %0d busy %0d out=%h, want %0d and %h",
                 i, lat, bn, out4, want_lat, p);
      end
    end
  endtask

  initial begin
    logic [127:0] kf, k3;
    kf = 128'h000102030405060708090a0b0c0d0e0f;
    test_reset();
    test_nr31_vector();
    test_roundtrip(64'h0123456789abcdef, kf);
    test_reuse(kf);
    test_reuse_after_rst(kf);
    test_abort_kexp(kf);
    test_abort_dec(k3);
    test_rst_mid_dec(k3);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
